// File: rtl/res_mem_reader.sv
// Result-memory read-back: fetches one packed line per read and streams its
// results out, lowest slice first, on a valid/ready port.
module res_mem_reader #(
    parameter int NUM_LINES    = 42,
    parameter int RES_PER_LINE = 4,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              mem_rd_adr,
    input  logic [RES_PER_LINE*DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);
    localparam int LINE_W = RES_PER_LINE * DATA_W;
    localparam int LCNT_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int ECNT_W = (RES_PER_LINE > 1) ? $clog2(RES_PER_LINE) : 1;
    localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(NUM_LINES - 1);
    localparam logic [ECNT_W-1:0] LAST_ELEM = ECNT_W'(RES_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [LCNT_W-1:0]   r_line_cnt;
    logic [LCNT_W-1:0]   w_line_cnt_nxt;
    logic [ECNT_W-1:0]   r_elem_cnt;
    logic [ECNT_W-1:0]   w_elem_cnt_nxt;
    logic [LINE_W-1:0]   r_line_reg;
    logic [DATA_W-1:0]   w_elem;
    logic                w_last_elem;
    logic                w_last_line;

    assign w_last_elem = (r_elem_cnt == LAST_ELEM);
    assign w_last_line = (r_line_cnt == LAST_LINE);

    // Element mux; counter values past the last slice select nothing.
    always_comb begin
        w_elem = '0;
        for (int i = 0; i < RES_PER_LINE; i++) begin
            if (r_elem_cnt == ECNT_W'(i)) begin
                w_elem = r_line_reg[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_line_cnt_nxt = r_line_cnt;
        w_elem_cnt_nxt = r_elem_cnt;
        mem_rd_en      = 1'b0;
        mem_rd_adr     = '0;
        out_valid      = 1'b0;
        out_data       = '0;
        out_last       = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy           = 1'b0;
                w_line_cnt_nxt = '0;
                w_elem_cnt_nxt = '0;
                if (start) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                mem_rd_en    = 1'b1;
                mem_rd_adr   = ADDR_W'(r_line_cnt);
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_elem_cnt_nxt = '0;
                w_next_state   = S_STREAM;
            end
            S_STREAM: begin
                out_valid = 1'b1;
                out_data  = w_elem;
                out_last  = w_last_line & w_last_elem;
                // Counters only move on an accepted transfer, so a stall holds the output.
                if (out_ready) begin
                    if (!w_last_elem) begin
                        w_elem_cnt_nxt = r_elem_cnt + 1'b1;
                    end else if (w_last_line) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_line_cnt_nxt = r_line_cnt + 1'b1;
                        w_next_state   = S_READ;
                    end
                end
            end
            S_DONE: begin
                done           = 1'b1;
                w_line_cnt_nxt = '0;
                w_elem_cnt_nxt = '0;
                w_next_state   = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_line_cnt <= '0;
            r_elem_cnt <= '0;
            r_line_reg <= '0;
        end else begin
            r_state    <= w_next_state;
            r_line_cnt <= w_line_cnt_nxt;
            r_elem_cnt <= w_elem_cnt_nxt;
            // Read data is only valid during the cycle after the strobe.
            if (r_state == S_WAIT) begin
                r_line_reg <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_res_mem_reader.sv
// Bench for res_mem_reader: a 42-line instance under random and directed
// backpressure, plus a 24-line instance, both against a queue-based model.
module tb_res_mem_reader;
    localparam int NL  = 42;
    localparam int NLB = 24;
    localparam int RPL = 4;
    localparam int DW  = 8;
    localparam int AW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_adr;
    logic [RPL*DW-1:0] mem_rd_data;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic              busy;
    logic              done;

    logic              start_b = 1'b0;
    logic              rd_en_b;
    logic [AW-1:0]     adr_b;
    logic [RPL*DW-1:0] rdata_b;
    logic [DW-1:0]     data_b;
    logic              vld_b;
    logic              rdy_b = 1'b1;
    logic              last_b;
    logic              busy_b;
    logic              done_b;

    logic [RPL*DW-1:0] mem [0:255];

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;

    res_mem_reader #(.NUM_LINES(NL), .RES_PER_LINE(RPL), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_rd_adr(mem_rd_adr), .mem_rd_data(mem_rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    res_mem_reader #(.NUM_LINES(NLB), .RES_PER_LINE(RPL), .DATA_W(DW), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .mem_rd_en(rd_en_b), .mem_rd_adr(adr_b), .mem_rd_data(rdata_b),
        .out_data(data_b), .out_valid(vld_b), .out_ready(rdy_b),
        .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // One-cycle read latency memory shared by both instances.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_adr];
        if (rd_en_b)   rdata_b     <= mem[adr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state for the 42-line instance.
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] adr_q [$];
    bit  m_busy = 1'b0;
    bit  m_done_next = 1'b0;
    bit  prev_stall = 1'b0;
    bit  lat_wait = 1'b0;
    bit  has_done;
    bit  is_last;
    logic [DW-1:0] prev_data = '0;
    int  lat_cnt = 0;
    int  pass_reads = 0;
    int  pass_xfers = 0;
    int  stall_seen = 0;

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done_next));
        if (!m_busy) begin
            chk("idle_vld", 32'(out_valid), 32'd0);
            chk("idle_rd", 32'(mem_rd_en), 32'd0);
            chk("idle_adr", 32'(mem_rd_adr), 32'd0);
            chk("idle_data", 32'(out_data), 32'd0);
            chk("idle_last", 32'(out_last), 32'd0);
        end
        if (prev_stall) begin
            chk("stall_vld", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (rst) begin
            exp_q.delete();
            adr_q.delete();
            m_busy = 1'b0;
            m_done_next = 1'b0;
            prev_stall = 1'b0;
            lat_wait = 1'b0;
        end else begin
            has_done = m_done_next;
            m_done_next = 1'b0;
            if (mem_rd_en) begin
                if (adr_q.size() == 0) chk("rd_extra", 32'(mem_rd_adr), 32'hFFFF_FFFF);
                else chk("rd_adr", 32'(mem_rd_adr), 32'(adr_q.pop_front()));
                pass_reads++;
            end
            if (lat_wait) begin
                lat_cnt++;
                if (out_valid) begin
                    chk("latency", 32'(lat_cnt), 32'd3);
                    lat_wait = 1'b0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("xfer_extra", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    is_last = (exp_q.size() == 1);
                    chk("data", 32'(out_data), 32'(exp_q.pop_front()));
                    chk("last", 32'(out_last), 32'(is_last));
                    pass_xfers++;
                    if (is_last) m_done_next = 1'b1;
                end
            end else if (out_valid && exp_q.size() > 0) begin
                stall_seen++;
                chk("stall_front", 32'(out_data), 32'(exp_q[0]));
                chk("stall_last", 32'(out_last), 32'(exp_q.size() == 1));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (start && !m_busy) begin
                m_busy = 1'b1;
                pass_reads = 0;
                pass_xfers = 0;
                lat_wait = 1'b1;
                lat_cnt = 0;
                for (int k = 0; k < NL; k++) begin
                    adr_q.push_back(AW'(k));
                    for (int e = 0; e < RPL; e++) exp_q.push_back(mem[k][8*e +: 8]);
                end
            end
            if (has_done) begin
                chk("pass_reads", 32'(pass_reads), 32'(NL));
                chk("pass_xfers", 32'(pass_xfers), 32'(NL*RPL));
                m_busy = 1'b0;
            end
        end
    end

    // Reference checks for the 24-line instance.
    int b_reads = 0;
    int b_xfers = 0;
    int b_done_seen = 0;
    bit b_last_prev = 1'b0;

    always @(negedge clk) begin
        chk("b_done", 32'(done_b), 32'(b_last_prev));
        b_last_prev = 1'b0;
        if (!rst) begin
            if (rd_en_b) begin
                chk("b_adr", 32'(adr_b), 32'(b_reads));
                chk("b_adr_rng", 32'(adr_b < AW'(NLB)), 32'd1);
                b_reads++;
            end
            if (vld_b && rdy_b) begin
                chk("b_data", 32'(data_b), 32'(mem[b_xfers/RPL][8*(b_xfers%RPL) +: 8]));
                chk("b_last", 32'(last_b), 32'(b_xfers == NLB*RPL-1));
                b_last_prev = (b_xfers == NLB*RPL-1);
                b_xfers++;
            end
            if (done_b) begin
                chk("b_reads", 32'(b_reads), 32'(NLB));
                chk("b_xfers", 32'(b_xfers), 32'(NLB*RPL));
                b_done_seen++;
            end
        end
    end

    // out_ready driver: 0 = tied high, 1 = random, 2 = 5-cycle stall on result 30.
    int stall_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1: out_ready = ($urandom_range(0, 1) != 0);
            2: begin
                if (pass_xfers == 30 && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: begin
                out_ready = 1'b1;
                stall_cnt = 0;
            end
        endcase
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < max_cyc) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 256; k++) mem[k] = $urandom();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_vld"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_rd"}, 32'(mem_rd_en), 32'd0);
        chk({tag, "_adr"}, 32'(mem_rd_adr), 32'd0);
    endtask

    initial begin
        int n;
        int s0;
        bit seen;
        for (int k = 0; k < 256; k++) mem[k] = {8'(k+3), 8'(k+2), 8'(k+1), 8'(k)};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_init");

        // Reset held 3 cycles in the middle of a stream.
        pulse_start();
        n = 0;
        while (pass_xfers < 10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t1_reach", 32'(pass_xfers >= 10), 32'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        repeat (5) @(posedge clk);

        // Full pass with the counting pattern, consumer always ready.
        pulse_start();
        wait_done(400, "t2_done");

        // Directed 5-cycle stall on line 7 element 2.
        fill_random();
        rdy_mode = 2;
        s0 = stall_seen;
        pulse_start();
        wait_done(400, "t3_done");
        chk("t3_stalls", 32'(stall_seen - s0), 32'd5);
        rdy_mode = 0;

        // start pulses during STREAM and in the DONE cycle are ignored.
        fill_random();
        pulse_start();
        n = 0;
        while (pass_xfers < 50 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_reach", 32'(pass_xfers >= 50), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
            n++;
        end
        chk("t4_done", 32'(seen), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_idle", 32'(busy), 32'd0);

        // Three back-to-back passes with random backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 3; p++) begin
            fill_random();
            pulse_start();
            wait_done(2000, "t6_done");
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        // 24-line instance.
        fill_random();
        @(posedge clk);
        #1 start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
            n++;
        end
        chk("t5_done", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        chk("t5_done_cnt", 32'(b_done_seen), 32'd1);
        chk("t5_idle", 32'(busy_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
